// File: rtl/haar_pkg.sv
// rtl/haar_pkg.sv - shared constants, state encoding and stage tables for the Haar cascade sequencer
package haar_pkg;

   localparam int DATA_WIDTH_16           = 16;
   localparam int ADDR_WIDTH              = 10;
   localparam int ACC_WIDTH               = 24;
   localparam int NUM_STAGES              = 3;
   localparam int NUM_CLASSIFIERS_STAGE_1 = 9;
   localparam int NUM_CLASSIFIERS_STAGE_2 = 16;
   localparam int NUM_CLASSIFIERS_STAGE_3 = 27;
   localparam int NUM_CLASSIFIER          = NUM_CLASSIFIERS_STAGE_1 + NUM_CLASSIFIERS_STAGE_2
                                          + NUM_CLASSIFIERS_STAGE_3;

   localparam int STAGE_SIZE [NUM_STAGES] = '{NUM_CLASSIFIERS_STAGE_1, NUM_CLASSIFIERS_STAGE_2,
                                              NUM_CLASSIFIERS_STAGE_3};
   localparam int STAGE_BASE [NUM_STAGES] = '{0, NUM_CLASSIFIERS_STAGE_1,
                                              NUM_CLASSIFIERS_STAGE_1 + NUM_CLASSIFIERS_STAGE_2};

   localparam int STAGE_THR_BASE = 0;
   localparam int CLS_BASE       = NUM_STAGES;
   localparam int WORDS_PER_CLS  = 3;

   localparam int STAGE_W = $clog2(NUM_STAGES + 1);
   localparam int CLS_W   = $clog2(NUM_CLASSIFIER);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_STHR,
      ST_RD_THR,
      ST_RD_LEFT,
      ST_RD_RIGHT,
      ST_FEAT,
      ST_ACC,
      ST_CHK,
      ST_DONE
   } state_t;

   function automatic logic [CLS_W-1:0] stage_last_cls(input logic [STAGE_W-1:0] stage);
      logic [CLS_W-1:0] last;
      last = '0;
      for (int i = 0; i < NUM_STAGES; i++)
         if (stage == STAGE_W'(i)) last = CLS_W'(STAGE_SIZE[i] - 1);
      return last;
   endfunction

   function automatic logic [CLS_W-1:0] stage_base(input logic [STAGE_W-1:0] stage);
      logic [CLS_W-1:0] base;
      base = '0;
      for (int i = 0; i < NUM_STAGES; i++)
         if (stage == STAGE_W'(i)) base = CLS_W'(STAGE_BASE[i]);
      return base;
   endfunction

   function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [DATA_WIDTH_16-1:0] v);
      return {{(ACC_WIDTH - DATA_WIDTH_16){v[DATA_WIDTH_16-1]}}, v};
   endfunction

endpackage

// File: rtl/haar_weak_classifier_acc.sv
// rtl/haar_weak_classifier_acc.sv - signed leaf select, stage accumulator and stage pass test
module haar_weak_classifier_acc
   import haar_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_WIDTH_16-1:0] rd_data,
   input  logic                     cap_stage_thr,
   input  logic                     cap_cls_thr,
   input  logic                     cap_left,
   input  logic                     cap_right,
   input  logic                     feat_load,
   input  logic [DATA_WIDTH_16-1:0] feat_value,
   input  logic                     acc_clear,
   input  logic                     acc_add,
   output logic                     stage_pass
);

   logic signed [DATA_WIDTH_16-1:0] stage_thr;
   logic signed [DATA_WIDTH_16-1:0] cls_thr;
   logic signed [DATA_WIDTH_16-1:0] leaf_left;
   logic signed [DATA_WIDTH_16-1:0] leaf_right;
   logic signed [DATA_WIDTH_16-1:0] feat;
   logic signed [ACC_WIDTH-1:0]     acc;
   logic signed [ACC_WIDTH-1:0]     leaf_sel;

   // Feature strictly below the classifier threshold takes the left leaf.
   assign leaf_sel   = (feat < cls_thr) ? sext(leaf_left) : sext(leaf_right);
   assign stage_pass = (acc >= sext(stage_thr));

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_thr  <= '0;
         cls_thr    <= '0;
         leaf_left  <= '0;
         leaf_right <= '0;
         feat       <= '0;
         acc        <= '0;
      end else begin
         if (cap_stage_thr) stage_thr  <= rd_data;
         if (cap_cls_thr)   cls_thr    <= rd_data;
         if (cap_left)      leaf_left  <= rd_data;
         if (cap_right)     leaf_right <= rd_data;
         if (feat_load)     feat       <= feat_value;
         if (acc_clear)
            acc <= '0;
         else if (acc_add)
            acc <= acc + leaf_sel;
      end
   end

endmodule

// File: rtl/haar_cascade_sequencer.sv
// rtl/haar_cascade_sequencer.sv - Haar cascade evaluation FSM with database address generation
// Define HAAR_STAGE_DEPTH_EN to add the stage_reached output.
module haar_cascade_sequencer
   import haar_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     face_detected,
`ifdef HAAR_STAGE_DEPTH_EN
   output logic [STAGE_W-1:0]       stage_reached,
`endif
   output logic                     mem_rd_en,
   output logic [ADDR_WIDTH-1:0]    mem_addr,
   input  logic [DATA_WIDTH_16-1:0] mem_rd_data,
   output logic                     feat_req,
   output logic [ADDR_WIDTH-1:0]    feat_idx,
   input  logic                     feat_valid,
   input  logic [DATA_WIDTH_16-1:0] feat_value
);

   state_t                state, state_next, prev_state;
   logic [STAGE_W-1:0]    stage;
   logic [CLS_W-1:0]      cls;
   logic                  stage_pass;
   logic                  last_cls;
   logic                  last_stage;
   logic                  acc_clear;
   logic [ADDR_WIDTH-1:0] cls_addr;

   assign last_cls   = (cls == stage_last_cls(stage));
   assign last_stage = (stage == STAGE_W'(NUM_STAGES - 1));
   assign feat_idx   = ADDR_WIDTH'(stage_base(stage)) + ADDR_WIDTH'(cls);
   assign cls_addr   = ADDR_WIDTH'(CLS_BASE) + ADDR_WIDTH'(WORDS_PER_CLS) * feat_idx;
   assign acc_clear  = ((state == ST_IDLE) && start)
                    || ((state == ST_CHK) && stage_pass && !last_stage);

   always_comb begin
      state_next = state;
      busy       = (state != ST_IDLE);
      done       = 1'b0;
      mem_rd_en  = 1'b0;
      mem_addr   = '0;
      feat_req   = 1'b0;
      case (state)
         ST_IDLE:
            if (start) state_next = ST_RD_STHR;
         ST_RD_STHR: begin
            mem_rd_en  = 1'b1;
            mem_addr   = ADDR_WIDTH'(STAGE_THR_BASE) + ADDR_WIDTH'(stage);
            state_next = ST_RD_THR;
         end
         ST_RD_THR: begin
            mem_rd_en  = 1'b1;
            mem_addr   = cls_addr;
            state_next = ST_RD_LEFT;
         end
         ST_RD_LEFT: begin
            mem_rd_en  = 1'b1;
            mem_addr   = cls_addr + ADDR_WIDTH'(1);
            state_next = ST_RD_RIGHT;
         end
         ST_RD_RIGHT: begin
            mem_rd_en  = 1'b1;
            mem_addr   = cls_addr + ADDR_WIDTH'(2);
            state_next = ST_FEAT;
         end
         ST_FEAT: begin
            feat_req = 1'b1;
            if (feat_valid) state_next = ST_ACC;
         end
         ST_ACC:
            state_next = last_cls ? ST_CHK : ST_RD_THR;
         ST_CHK:
            state_next = (stage_pass && !last_stage) ? ST_RD_STHR : ST_DONE;
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default:
            state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         prev_state    <= ST_IDLE;
         stage         <= '0;
         cls           <= '0;
         face_detected <= 1'b0;
      end else begin
         state      <= state_next;
         prev_state <= state;
         case (state)
            ST_IDLE:
               if (start) begin
                  stage         <= '0;
                  cls           <= '0;
                  face_detected <= 1'b0;
               end
            ST_ACC:
               cls <= last_cls ? '0 : cls + CLS_W'(1);
            ST_CHK:
               if (stage_pass) begin
                  if (last_stage) face_detected <= 1'b1;
                  else            stage         <= stage + STAGE_W'(1);
               end
            default: ;
         endcase
      end
   end

`ifdef HAAR_STAGE_DEPTH_EN
   always_ff @(posedge clk) begin
      if (reset)
         stage_reached <= '0;
      else if ((state == ST_IDLE) && start)
         stage_reached <= '0;
      else if ((state == ST_CHK) && stage_pass)
         stage_reached <= stage_reached + STAGE_W'(1);
   end
`else
   // Without the depth output, face_detected alone reports the outcome.
`endif

   // Read data lands one cycle after its strobe, so captures key off the previous state.
   haar_weak_classifier_acc u_acc (
      .clk           (clk),
      .reset         (reset),
      .rd_data       (mem_rd_data),
      .cap_stage_thr (prev_state == ST_RD_STHR),
      .cap_cls_thr   (prev_state == ST_RD_THR),
      .cap_left      (prev_state == ST_RD_LEFT),
      .cap_right     (prev_state == ST_RD_RIGHT),
      .feat_load     ((state == ST_FEAT) && feat_valid),
      .feat_value    (feat_value),
      .acc_clear     (acc_clear),
      .acc_add       (state == ST_ACC),
      .stage_pass    (stage_pass)
   );

endmodule
